// File: rtl/i2cs_arb_pkg.sv
// Shared types for the I2C-peripheral register-port arbiter.
package i2cs_arb_pkg;

    localparam int ARB_ADDR_W = 8;
    localparam int ARB_DATA_W = 8;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    typedef enum logic {
        REQ_I2C,
        REQ_APB
    } req_id_t;

    // Default-width access record; the top rebuilds it from its own width parameters.
    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
    } access_t;

endpackage

// File: rtl/i2cs_arb_starve_guard.sv
// Winner selection with APB starvation bound: wait counter, last-winner memory.
// The lock input freezes the counter and hides APB from arbitration.
module i2cs_arb_starve_guard
    import i2cs_arb_pkg::*;
#(
    parameter int APB_MAX_WAIT = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    arb_en,
    input  logic    i2c_req,
    input  logic    apb_req,
    input  logic    lock,
    output logic    grant_vld,
    output req_id_t winner
);

    localparam int CNT_W = (APB_MAX_WAIT < 1) ? 1 : $clog2(APB_MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(APB_MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt;
    req_id_t          last_winner;
    logic             apb_ok;
    logic             force_apb;

    // Requiring the previous winner to be I2C makes APB_MAX_WAIT=0 strictly alternate;
    // for larger limits wait_cnt can only reach the limit after an I2C grant anyway.
    always_comb begin
        apb_ok    = apb_req & ~lock;
        force_apb = (wait_cnt == WAIT_MAX) && (last_winner == REQ_I2C);
        grant_vld = arb_en & (i2c_req | apb_ok);
        winner    = REQ_I2C;
        if (apb_ok && (!i2c_req || force_apb)) begin
            winner = REQ_APB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            last_winner <= REQ_APB;
        end else if (grant_vld) begin
            last_winner <= winner;
            if (winner == REQ_APB) begin
                wait_cnt <= '0;
            end else if (apb_ok && (wait_cnt != WAIT_MAX)) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/i2cs_reg_port_arbiter.sv
// Shares the register-file port between the I2C byte engine (priority) and APB decoder.
// Optional macro I2CS_ARB_LOCK_EN adds i2c_lock_i to hold APB off during I2C bursts.
module i2cs_reg_port_arbiter
    import i2cs_arb_pkg::*;
#(
    parameter int ADDR_W       = ARB_ADDR_W,
    parameter int DATA_W       = ARB_DATA_W,
    parameter int APB_MAX_WAIT = 4
) (
    input  logic              apb_pclk_i,
    input  logic              apb_presetn_i,
`ifdef I2CS_ARB_LOCK_EN
    input  logic              i2c_lock_i,
`endif
    input  logic              i2c_req_i,
    input  logic              i2c_we_i,
    input  logic [ADDR_W-1:0] i2c_addr_i,
    input  logic [DATA_W-1:0] i2c_wdata_i,
    output logic              i2c_gnt_o,
    output logic              i2c_rvalid_o,
    output logic [DATA_W-1:0] i2c_rdata_o,
    input  logic              apb_req_i,
    input  logic              apb_we_i,
    input  logic [ADDR_W-1:0] apb_addr_i,
    input  logic [DATA_W-1:0] apb_wdata_i,
    output logic              apb_gnt_o,
    output logic              apb_rvalid_o,
    output logic [DATA_W-1:0] apb_rdata_o,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    output logic              reg_we_o,
    output logic              reg_re_o,
    input  logic [DATA_W-1:0] reg_rdata_i
);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } port_acc_t;

    state_t    state_q;
    state_t    state_d;
    logic      grant_vld;
    req_id_t   winner;
    logic      lock;
    port_acc_t i2c_acc;
    port_acc_t apb_acc;
    port_acc_t win_acc;

`ifdef I2CS_ARB_LOCK_EN
    assign lock = i2c_lock_i;
`else
    assign lock = 1'b0;
`endif

    assign i2c_acc = {i2c_we_i, i2c_addr_i, i2c_wdata_i};
    assign apb_acc = {apb_we_i, apb_addr_i, apb_wdata_i};

    i2cs_arb_starve_guard #(
        .APB_MAX_WAIT(APB_MAX_WAIT)
    ) u_starve_guard (
        .clk      (apb_pclk_i),
        .rst_n    (apb_presetn_i),
        .arb_en   (state_q == IDLE),
        .i2c_req  (i2c_req_i),
        .apb_req  (apb_req_i),
        .lock     (lock),
        .grant_vld(grant_vld),
        .winner   (winner)
    );

    always_comb begin
        state_d = state_q;
        win_acc = (winner == REQ_APB) ? apb_acc : i2c_acc;
        unique case (state_q)
            IDLE:    if (grant_vld) state_d = GRANT;
            GRANT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge apb_pclk_i or negedge apb_presetn_i) begin
        if (!apb_presetn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobes and grants live for exactly the GRANT cycle; read data is captured as it ends.
    always_ff @(posedge apb_pclk_i or negedge apb_presetn_i) begin
        if (!apb_presetn_i) begin
            i2c_gnt_o    <= 1'b0;
            apb_gnt_o    <= 1'b0;
            i2c_rvalid_o <= 1'b0;
            apb_rvalid_o <= 1'b0;
            i2c_rdata_o  <= '0;
            apb_rdata_o  <= '0;
            reg_addr_o   <= '0;
            reg_wdata_o  <= '0;
            reg_we_o     <= 1'b0;
            reg_re_o     <= 1'b0;
        end else begin
            i2c_gnt_o    <= 1'b0;
            apb_gnt_o    <= 1'b0;
            i2c_rvalid_o <= 1'b0;
            apb_rvalid_o <= 1'b0;
            reg_we_o     <= 1'b0;
            reg_re_o     <= 1'b0;
            if ((state_q == IDLE) && grant_vld) begin
                reg_addr_o  <= win_acc.addr;
                reg_wdata_o <= win_acc.wdata;
                reg_we_o    <= win_acc.we;
                reg_re_o    <= ~win_acc.we;
                i2c_gnt_o   <= (winner == REQ_I2C);
                apb_gnt_o   <= (winner == REQ_APB);
            end
            if ((state_q == GRANT) && reg_re_o) begin
                if (i2c_gnt_o) begin
                    i2c_rdata_o  <= reg_rdata_i;
                    i2c_rvalid_o <= 1'b1;
                end
                if (apb_gnt_o) begin
                    apb_rdata_o  <= reg_rdata_i;
                    apb_rvalid_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2cs_reg_port_arbiter.sv
// Scoreboard bench for i2cs_reg_port_arbiter (APB_MAX_WAIT=4 and =0 instances).
`timescale 1ns/1ps
module tb_i2cs_reg_port_arbiter;

    typedef struct {
        bit         who;   // 0 = I2C, 1 = APB
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } grant_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Main DUT (APB_MAX_WAIT = 4)
    logic       i2c_req = 1'b0, i2c_we = 1'b0;
    logic [7:0] i2c_addr = '0, i2c_wdata = '0;
    logic       i2c_gnt, i2c_rvalid;
    logic [7:0] i2c_rdata;
    logic       apb_req = 1'b0, apb_we = 1'b0;
    logic [7:0] apb_addr = '0, apb_wdata = '0;
    logic       apb_gnt, apb_rvalid;
    logic [7:0] apb_rdata;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_we, reg_re;
`ifdef I2CS_ARB_LOCK_EN
    logic       i2c_lock = 1'b0;
    logic       d0_lock = 1'b0;
`endif

    // Alternation DUT (APB_MAX_WAIT = 0)
    logic       d0_i2c_req = 1'b0, d0_apb_req = 1'b0;
    logic       d0_i2c_gnt, d0_i2c_rvalid, d0_apb_gnt, d0_apb_rvalid;
    logic [7:0] d0_i2c_rdata, d0_apb_rdata, d0_reg_addr, d0_reg_wdata;
    logic       d0_reg_we, d0_reg_re;

    // Register file model
    logic [7:0] mem [256];
    logic       mem_init = 1'b1;
    assign reg_rdata = mem[reg_addr];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
            mem[8'h10] <= 8'hA5;
        end else if (reg_we) begin
            mem[reg_addr] <= reg_wdata;
        end
    end

    i2cs_reg_port_arbiter #(.ADDR_W(8), .DATA_W(8), .APB_MAX_WAIT(4)) dut (
        .apb_pclk_i   (clk),
        .apb_presetn_i(rst_n),
`ifdef I2CS_ARB_LOCK_EN
        .i2c_lock_i   (i2c_lock),
`endif
        .i2c_req_i    (i2c_req),
        .i2c_we_i     (i2c_we),
        .i2c_addr_i   (i2c_addr),
        .i2c_wdata_i  (i2c_wdata),
        .i2c_gnt_o    (i2c_gnt),
        .i2c_rvalid_o (i2c_rvalid),
        .i2c_rdata_o  (i2c_rdata),
        .apb_req_i    (apb_req),
        .apb_we_i     (apb_we),
        .apb_addr_i   (apb_addr),
        .apb_wdata_i  (apb_wdata),
        .apb_gnt_o    (apb_gnt),
        .apb_rvalid_o (apb_rvalid),
        .apb_rdata_o  (apb_rdata),
        .reg_addr_o   (reg_addr),
        .reg_wdata_o  (reg_wdata),
        .reg_we_o     (reg_we),
        .reg_re_o     (reg_re),
        .reg_rdata_i  (reg_rdata)
    );

    i2cs_reg_port_arbiter #(.ADDR_W(8), .DATA_W(8), .APB_MAX_WAIT(0)) dut0 (
        .apb_pclk_i   (clk),
        .apb_presetn_i(rst_n),
`ifdef I2CS_ARB_LOCK_EN
        .i2c_lock_i   (d0_lock),
`endif
        .i2c_req_i    (d0_i2c_req),
        .i2c_we_i     (1'b0),
        .i2c_addr_i   (8'h55),
        .i2c_wdata_i  (8'hAA),
        .i2c_gnt_o    (d0_i2c_gnt),
        .i2c_rvalid_o (d0_i2c_rvalid),
        .i2c_rdata_o  (d0_i2c_rdata),
        .apb_req_i    (d0_apb_req),
        .apb_we_i     (1'b0),
        .apb_addr_i   (8'h55),
        .apb_wdata_i  (8'hAA),
        .apb_gnt_o    (d0_apb_gnt),
        .apb_rvalid_o (d0_apb_rvalid),
        .apb_rdata_o  (d0_apb_rdata),
        .reg_addr_o   (d0_reg_addr),
        .reg_wdata_o  (d0_reg_wdata),
        .reg_we_o     (d0_reg_we),
        .reg_re_o     (d0_reg_re),
        .reg_rdata_i  (8'h3C)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Scoreboard state
    grant_t     gq[$];
    logic [7:0] rq_i2c[$];
    logic [7:0] rq_apb[$];
    bit         due_i2c = 0, due_apb = 0;
    logic [7:0] hold_i2c = '0, hold_apb = '0;

    function automatic void exp_g(input bit who, input bit we, input logic [7:0] a,
                                  input logic [7:0] d, input logic [7:0] r);
        grant_t g;
        g.who = who; g.we = we; g.addr = a; g.wdata = d; g.rdata = r;
        gq.push_back(g);
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (i2c_rvalid || apb_rvalid || due_i2c || due_apb) begin
                check_eq("i2c_rvalid", i2c_rvalid, due_i2c);
                check_eq("apb_rvalid", apb_rvalid, due_apb);
                if (due_i2c && rq_i2c.size() > 0) hold_i2c = rq_i2c.pop_front();
                if (due_apb && rq_apb.size() > 0) hold_apb = rq_apb.pop_front();
                check_eq("i2c_rdata", i2c_rdata, hold_i2c);
                check_eq("apb_rdata", apb_rdata, hold_apb);
            end
            due_i2c = 0;
            due_apb = 0;
            if (i2c_gnt || apb_gnt) begin
                if (gq.size() == 0) begin
                    check_eq("unexp_gnt", {i2c_gnt, apb_gnt}, 0);
                end else begin
                    grant_t g;
                    g = gq.pop_front();
                    check_eq("gnt_apb", apb_gnt, g.who);
                    check_eq("gnt_i2c", i2c_gnt, !g.who);
                    check_eq("gnt_we", reg_we, g.we);
                    check_eq("gnt_re", reg_re, !g.we);
                    check_eq("gnt_addr", reg_addr, g.addr);
                    if (g.we) check_eq("gnt_wdata", reg_wdata, g.wdata);
                    if (!g.we) begin
                        if (g.who) begin due_apb = 1; rq_apb.push_back(g.rdata); end
                        else       begin due_i2c = 1; rq_i2c.push_back(g.rdata); end
                    end
                end
            end
        end
    end

    task automatic drive_i2c(input logic we, input logic [7:0] a, input logic [7:0] d, output int waited);
        i2c_we = we; i2c_addr = a; i2c_wdata = d; i2c_req = 1'b1; waited = 0;
        do begin @(posedge clk); #1; waited++; end while (!i2c_gnt && waited < 40);
        if (!i2c_gnt) check_eq("i2c_gnt_timeout", i2c_gnt, 1);
        i2c_req = 1'b0;
    endtask

    task automatic drive_apb(input logic we, input logic [7:0] a, input logic [7:0] d, output int waited);
        apb_we = we; apb_addr = a; apb_wdata = d; apb_req = 1'b1; waited = 0;
        do begin @(posedge clk); #1; waited++; end while (!apb_gnt && waited < 40);
        if (!apb_gnt) check_eq("apb_gnt_timeout", apb_gnt, 1);
        apb_req = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w_i, w_a, w_a2, n, rv_i, rv_a;

        // Reset values
        repeat (3) @(posedge clk);
        #3;
        check_eq("rst_ctl", {i2c_gnt, apb_gnt, i2c_rvalid, apb_rvalid, reg_we, reg_re}, 0);
        check_eq("rst_rdata", {i2c_rdata, apb_rdata}, 0);
        check_eq("rst_reg", {reg_addr, reg_wdata}, 0);
        rst_n = 1'b1;
        mem_init = 1'b0;

        // Uncontended APB read
        @(posedge clk); #1;
        exp_g(1, 0, 8'h10, 8'h00, 8'hA5);
        drive_apb(1'b0, 8'h10, 8'h00, w_a);
        check_eq("t1_gnt_lat", w_a, 1);
        check_eq("t1_re", reg_re, 1);
        @(posedge clk); #1;
        check_eq("t1_rvalid", apb_rvalid, 1);
        check_eq("t1_rdata", apb_rdata, 8'hA5);
        check_eq("t1_i2c_quiet", {i2c_gnt, i2c_rvalid, i2c_rdata}, 0);
        settle();

        // Simultaneous: I2C write then APB read of the same address
        @(posedge clk); #1;
        exp_g(0, 1, 8'h04, 8'h22, 8'h00);
        exp_g(1, 0, 8'h04, 8'h00, 8'h22);
        fork
            drive_i2c(1'b1, 8'h04, 8'h22, w_i);
            drive_apb(1'b0, 8'h04, 8'h00, w_a);
        join
        check_eq("t2_i2c_lat", w_i, 1);
        check_eq("t2_apb_lat", w_a, 3);
        settle();
        check_eq("t2_apb_rdata", apb_rdata, 8'h22);

        // Starvation bound: 4 I2C grants, then APB, twice
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) exp_g(0, 1, 8'h20 + 8'(k), 8'(k), 8'h00);
        exp_g(1, 0, 8'h10, 8'h00, 8'hA5);
        for (int k = 4; k < 8; k++) exp_g(0, 1, 8'h20 + 8'(k), 8'(k), 8'h00);
        exp_g(1, 0, 8'h23, 8'h00, 8'h03);
        for (int k = 8; k < 10; k++) exp_g(0, 1, 8'h20 + 8'(k), 8'(k), 8'h00);
        fork
            begin
                int wi;
                for (int k = 0; k < 10; k++) drive_i2c(1'b1, 8'h20 + 8'(k), 8'(k), wi);
            end
            begin
                drive_apb(1'b0, 8'h10, 8'h00, w_a);
                drive_apb(1'b0, 8'h23, 8'h00, w_a2);
            end
        join
        check_eq("t3_apb_wait1", w_a, 9);
        check_eq("t3_apb_wait2", w_a2, 10);
        settle();

        // Async reset during the GRANT cycle of an APB read
        @(posedge clk); #1;
        apb_we = 1'b0; apb_addr = 8'h10; apb_req = 1'b1;
        @(posedge clk); #1;
        check_eq("t4_pre_gnt", {apb_gnt, reg_re}, 2'b11);
        #1;
        rst_n = 1'b0;
        apb_req = 1'b0;
        gq.delete(); rq_i2c.delete(); rq_apb.delete();
        due_i2c = 0; due_apb = 0; hold_i2c = '0; hold_apb = '0;
        #1;
        check_eq("t4_async_drop", {apb_gnt, reg_re}, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        n = 0;
        repeat (4) begin @(posedge clk); #1; if (apb_rvalid) n++; end
        check_eq("t4_no_rvalid", n, 0);
        check_eq("t4_rdata_clr", apb_rdata, 0);
        exp_g(0, 0, 8'h04, 8'h00, 8'h22);
        exp_g(1, 1, 8'h30, 8'h77, 8'h00);
        fork
            drive_i2c(1'b0, 8'h04, 8'h00, w_i);
            drive_apb(1'b1, 8'h30, 8'h77, w_a);
        join
        check_eq("t4_i2c_first", w_i, 1);
        settle();
        exp_g(1, 0, 8'h30, 8'h00, 8'h77);
        drive_apb(1'b0, 8'h30, 8'h00, w_a);
        settle();
        check_eq("t4_i2c_rdata", i2c_rdata, 8'h22);

`ifdef I2CS_ARB_LOCK_EN
        // Lock holds APB off; release lets it in promptly
        @(posedge clk); #1;
        i2c_lock = 1'b1;
        exp_g(1, 0, 8'h10, 8'h00, 8'hA5);
        apb_we = 1'b0; apb_addr = 8'h10; apb_req = 1'b1;
        n = 0;
        repeat (20) begin @(posedge clk); #1; if (apb_gnt) n++; end
        check_eq("t5_lock_no_apb", n, 0);
        i2c_lock = 1'b0;
        w_a = 0;
        do begin @(posedge clk); #1; w_a++; end while (!apb_gnt && w_a < 4);
        check_eq("t5_rel_gnt", apb_gnt, 1);
        check_eq("t5_rel_lat", (w_a <= 2), 1);
        apb_req = 1'b0;
        settle();
`endif

        // APB_MAX_WAIT = 0: strict alternation under continuous contention
        @(posedge clk); #1;
        d0_i2c_req = 1'b1; d0_apb_req = 1'b1;
        n = 0; rv_i = 0; rv_a = 0;
        repeat (16) begin
            @(posedge clk); #1;
            if (d0_i2c_rvalid) rv_i++;
            if (d0_apb_rvalid) rv_a++;
            if (d0_i2c_gnt || d0_apb_gnt) begin
                check_eq("t6_alt_who", {d0_i2c_gnt, d0_apb_gnt}, (n % 2) ? 2'b01 : 2'b10);
                check_eq("t6_alt_acc", {d0_reg_addr, d0_reg_wdata, d0_reg_we, d0_reg_re}, {8'h55, 8'hAA, 2'b01});
                n++;
            end
        end
        d0_i2c_req = 1'b0; d0_apb_req = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (d0_i2c_rvalid) rv_i++;
            if (d0_apb_rvalid) rv_a++;
            if (d0_i2c_gnt || d0_apb_gnt) n++;
        end
        check_eq("t6_grants", n, 8);
        check_eq("t6_rvalid", {rv_i[7:0], rv_a[7:0]}, {8'd4, 8'd4});
        check_eq("t6_rdata", {d0_i2c_rdata, d0_apb_rdata}, {8'h3C, 8'h3C});

        check_eq("sb_grants_left", gq.size(), 0);
        check_eq("sb_reads_left", rq_i2c.size() + rq_apb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
